// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/state types and helpers for the ALU arbiter slice
package alu_pkg;

    localparam int ALU_DATA_W = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= 3'b100;
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational 16-bit ALU; bit DATA_W carries add carry / sub borrow
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic [DATA_W-1:0] i_in1,
    input  logic [DATA_W-1:0] i_in2,
    input  logic [2:0]        i_op,
    output logic [DATA_W:0]   o_result,
    output logic              o_err
);

    always_comb begin
        o_result = '0;
        o_err    = 1'b0;
        if (!is_legal_op(i_op)) begin
            o_err = 1'b1;
        end else begin
            case (alu_op_e'(i_op))
                OP_ADD:  o_result = {1'b0, i_in1} + {1'b0, i_in2};
                OP_SUB:  o_result = {1'b0, i_in1} - {1'b0, i_in2};
                OP_AND:  o_result = {1'b0, i_in1 & i_in2};
                OP_OR:   o_result = {1'b0, i_in1 | i_in2};
                OP_XOR:  o_result = {1'b0, i_in1 ^ i_in2};
                default: o_result = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between NUM_REQ requesters
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = ALU_DATA_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_in1,
    input  logic [NUM_REQ*DATA_W-1:0] req_in2,
    input  logic [NUM_REQ*3-1:0]      req_op,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W:0]           rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [15:0]               done_count
);

    arb_state_e          r_state;
    logic [ID_W-1:0]     r_last_grant;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_in1;
    logic [DATA_W-1:0]   r_in2;
    logic [2:0]          r_op;
    logic                r_rsp_valid;
    logic [DATA_W:0]     r_rsp_data;
    logic [ID_W-1:0]     r_rsp_id;
    logic                r_rsp_err;
    logic                r_busy;
    logic [15:0]         r_done_count;

    logic                w_found;
    logic [ID_W-1:0]     w_winner;
    logic [ID_W-1:0]     w_cand;
    int                  w_idx;
    logic [DATA_W:0]     w_result;
    logic                w_err;

    // Search starts just past the last grant so every active requester gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        w_cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx  = (int'(r_last_grant) + k) % NUM_REQ;
            w_cand = ID_W'(w_idx);
            if (!w_found && req_valid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // Gated by reset so the accept lines read zero the moment reset asserts.
    assign req_ready = (reset && r_state == IDLE && w_found) ?
                       (NUM_REQ'(1) << w_winner) : '0;

    alu_core #(.DATA_W(DATA_W)) u_alu_core (
        .i_in1    (r_in1),
        .i_in2    (r_in2),
        .i_op     (r_op),
        .o_result (w_result),
        .o_err    (w_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_id         <= '0;
            r_in1        <= '0;
            r_in2        <= '0;
            r_op         <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_id     <= '0;
            r_rsp_err    <= 1'b0;
            r_busy       <= 1'b0;
            r_done_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_in1        <= req_in1[w_winner*DATA_W +: DATA_W];
                        r_in2        <= req_in2[w_winner*DATA_W +: DATA_W];
                        r_op         <= req_op[w_winner*3 +: 3];
                        r_id         <= w_winner;
                        r_last_grant <= w_winner;
                        r_busy       <= 1'b1;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= w_result;
                    r_rsp_err   <= w_err;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid  <= 1'b0;
                        r_done_count <= r_done_count + 16'd1;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_id     = r_rsp_id;
    assign rsp_err    = r_rsp_err;
    assign busy       = r_busy;
    assign done_count = r_done_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed bench with a transaction-level model of arbitration and ALU results
module tb_alu_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*W-1:0]    req_in1 = '0;
    logic [N*W-1:0]    req_in2 = '0;
    logic [N*3-1:0]    req_op = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [W:0]        rsp_data;
    logic [1:0]        rsp_id;
    logic              rsp_err;
    logic              busy;
    logic [15:0]       done_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    alu_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W:0] data;
        int         id;
        logic       err;
        int         due;
    } exp_t;

    exp_t       m_q[$];
    int         m_last = N - 1;
    bit         m_out = 1'b0;
    int         m_done = 0;
    int         grant_log[$];
    int         acc_cyc[$];
    logic [W:0] acc_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event not seen within 30 cycles, required it to occur", name);
    endtask

    // Result as the opcode table defines it: {err, 17-bit result}.
    function automatic logic [17:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] op);
        logic [31:0] v;
        case (op)
            3'd0: v = 32'(a) + 32'(b);
            3'd1: v = 32'(a) - 32'(b);
            3'd2: v = {16'h0, a & b};
            3'd3: v = {16'h0, a | b};
            3'd4: v = {16'h0, a ^ b};
            default: return {1'b1, 17'h0};
        endcase
        return {1'b0, v[16:0]};
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] er;
        int           win;
        logic [17:0]  r;
        exp_t         e;
        if (!reset) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_data", 32'(rsp_data), 0);
            chk("rst_rsp_id", 32'(rsp_id), 0);
            chk("rst_rsp_err", 32'(rsp_err), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done_count", 32'(done_count), 0);
            m_q.delete();
            m_out  = 1'b0;
            m_last = N - 1;
            m_done = 0;
        end else begin
            er  = '0;
            win = -1;
            if (!m_out) begin
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (m_last + k) % N;
                    if (win < 0 && req_valid[idx]) win = idx;
                end
            end
            if (win >= 0) er[win] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(er));
            chk("busy", 32'(busy), 32'(m_out));
            chk("done_count", 32'(done_count), 32'(m_done));
            if (m_q.size() > 0 && cyc >= m_q[0].due) begin
                chk("rsp_valid", 32'(rsp_valid), 1);
                chk("rsp_data", 32'(rsp_data), 32'(m_q[0].data));
                chk("rsp_id", 32'(rsp_id), 32'(m_q[0].id));
                chk("rsp_err", 32'(rsp_err), 32'(m_q[0].err));
                if (rsp_ready) begin
                    void'(m_q.pop_front());
                    m_out  = 1'b0;
                    m_done = (m_done + 1) % 65536;
                    acc_cyc.push_back(cyc);
                    acc_data.push_back(rsp_data);
                end
            end else begin
                chk("rsp_valid_quiet", 32'(rsp_valid), 0);
            end
            if (win >= 0) begin
                r      = ref_alu(req_in1[win*W +: W], req_in2[win*W +: W], req_op[win*3 +: 3]);
                e.data = r[16:0];
                e.err  = r[17];
                e.id   = win;
                e.due  = cyc + 2;
                m_q.push_back(e);
                m_out  = 1'b1;
                m_last = win;
                grant_log.push_back(win);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] op);
        req_in1[id*W +: W] = a;
        req_in2[id*W +: W] = b;
        req_op[id*3 +: 3]  = op;
    endtask

    task automatic wait_ready(input int id, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            #1;
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            #1;
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_op(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, input logic [16:0] exp_d, input logic exp_e,
                         input string name);
        bit ok;
        set_req(id, a, b, op);
        req_valid[id] = 1'b1;
        wait_ready(id, ok);
        if (!ok) begin
            timeout({name, "_ready"});
            req_valid[id] = 1'b0;
            return;
        end
        tick();
        req_valid[id] = 1'b0;
        set_req(id, ~a, ~b, 3'b000);
        wait_rsp(ok);
        if (!ok) begin
            timeout({name, "_rsp"});
            return;
        end
        chk({name, "_data"}, 32'(rsp_data), 32'(exp_d));
        chk({name, "_err"}, 32'(rsp_err), 32'(exp_e));
        chk({name, "_id"}, 32'(rsp_id), 32'(id));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        bit ok;

        req_valid = 4'b0100;
        set_req(2, 16'h0003, 16'h0005, 3'b000);
        #3;
        chk("t0_req_ready", 32'(req_ready), 0);
        chk("t0_busy", 32'(busy), 0);
        chk("t0_rsp_valid", 32'(rsp_valid), 0);
        chk("t0_done", 32'(done_count), 0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("t1_req_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        set_req(2, 16'hAAAA, 16'h5555, 3'b001);
        tick();
        #1;
        chk("t1_rsp_valid", 32'(rsp_valid), 1);
        chk("t1_rsp_data", 32'(rsp_data), 32'h00008);
        chk("t1_rsp_id", 32'(rsp_id), 2);
        chk("t1_rsp_err", 32'(rsp_err), 0);
        tick();
        #1;
        chk("t1_done", 32'(done_count), 1);
        chk("t1_busy", 32'(busy), 0);

        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        grant_log.delete();
        acc_cyc.delete();
        acc_data.delete();
        for (int i = 0; i < N; i++) set_req(i, 16'h0000, 16'h0001, 3'b001);
        req_valid = '1;
        repeat (15) tick();
        req_valid = '0;
        repeat (3) tick();
        chk("t2_grant_count", 32'(grant_log.size()), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            chk("t2_grant_order", 32'(grant_log[i]), 32'(i % N));
        chk("t2_rsp_count", 32'(acc_cyc.size()), 5);
        for (int i = 1; i < acc_cyc.size(); i++)
            chk("t2_rsp_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 3);
        for (int i = 0; i < acc_data.size(); i++)
            chk("t2_rsp_data", 32'(acc_data[i]), 32'h1FFFF);

        do_op(1, 16'hFFFF, 16'h0001, 3'b000, 17'h10000, 1'b0, "carry");
        do_op(3, 16'hF0F0, 16'h0FF0, 3'b100, 17'h0FF00, 1'b0, "xor");
        do_op(0, 16'hF0F0, 16'h0FF0, 3'b010, 17'h000F0, 1'b0, "and");
        do_op(2, 16'hF0F0, 16'h0FF0, 3'b011, 17'h0FFF0, 1'b0, "or");
        do_op(1, 16'hF0F0, 16'h0FF0, 3'b111, 17'h00000, 1'b1, "illegal");
        do_op(3, 16'h1234, 16'h0234, 3'b001, 17'h01000, 1'b0, "sub");

        rsp_ready = 1'b0;
        set_req(1, 16'h00FF, 16'h0F0F, 3'b011);
        req_valid[1] = 1'b1;
        wait_ready(1, ok);
        if (!ok) timeout("bp_ready");
        tick();
        req_valid[1] = 1'b0;
        set_req(0, 16'h0005, 16'h0006, 3'b000);
        req_valid[0] = 1'b1;
        wait_rsp(ok);
        if (!ok) timeout("bp_rsp");
        repeat (5) begin
            tick();
            #1;
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_data", 32'(rsp_data), 32'h00FFF);
            chk("bp_id", 32'(rsp_id), 1);
            chk("bp_req_ready", 32'(req_ready), 0);
            chk("bp_busy", 32'(busy), 1);
        end
        rsp_ready = 1'b1;
        tick();
        #1;
        chk("bp_after_valid", 32'(rsp_valid), 0);
        chk("bp_after_busy", 32'(busy), 0);
        chk("bp_next_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        wait_rsp(ok);
        if (!ok) timeout("bp_next_rsp");
        chk("bp_next_data", 32'(rsp_data), 32'h0000B);
        chk("bp_next_id", 32'(rsp_id), 0);
        tick();

        set_req(2, 16'h0007, 16'h0008, 3'b000);
        req_valid[2] = 1'b1;
        wait_ready(2, ok);
        if (!ok) timeout("r5_ready");
        tick();
        set_req(0, 16'h0001, 16'h0001, 3'b000);
        req_valid = 4'b0101;
        #1;
        reset = 1'b0;
        #1;
        chk("r5_req_ready", 32'(req_ready), 0);
        chk("r5_rsp_valid", 32'(rsp_valid), 0);
        chk("r5_rsp_data", 32'(rsp_data), 0);
        chk("r5_rsp_id", 32'(rsp_id), 0);
        chk("r5_busy", 32'(busy), 0);
        chk("r5_done", 32'(done_count), 0);
        tick();
        tick();
        #1;
        chk("r5_no_rsp", 32'(rsp_valid), 0);
        tick();
        reset = 1'b1;
        #1;
        chk("r5_first_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        wait_rsp(ok);
        if (!ok) timeout("r5_rsp");
        chk("r5_rsp_data_after", 32'(rsp_data), 32'h00002);
        chk("r5_rsp_id_after", 32'(rsp_id), 0);
        tick();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
